// File: rtl/rat_reduce.sv
// Reduces a fraction num/den to lowest terms via binary GCD and two restoring dividers.
// Latency: 2 cycles for zero-numerator/zero-denominator, otherwise at most 4*WIDTH+4 cycles from accept.
// Backpressure: single-entry; in_ready only in IDLE, result held in DONE until out_ready.
// Optional feature: define RAT_REDUCE_SIGN_NORM_EN to treat in_den as two's complement
// and normalise its sign into the numerator so out_den is never negative.
module rat_reduce #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_num,
    input  logic [WIDTH-1:0] in_den,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_num,
    output logic [WIDTH-1:0] out_den,
    output logic             out_div_zero
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, GCD, DIV, DONE} state_t;

    state_t           state_q, state_d;
    logic             sign_q, sign_d;
    logic             zero_q, zero_d;      // numerator was zero: short-cut to 0/1
    logic             dz_q, dz_d;          // denominator was zero: pass-through
    logic [WIDTH-1:0] mag_q, mag_d;        // |num|
    logic [WIDTH-1:0] den_q, den_d;
    logic [WIDTH-1:0] ga_q, ga_d;          // Stein GCD working operands
    logic [WIDTH-1:0] gb_q, gb_d;
    logic [WIDTH-1:0] g_q, g_d;            // final gcd, divisor for both dividers
    logic [CW-1:0]    k_q, k_d;            // shared power of two
    logic [CW-1:0]    cnt_q, cnt_d;        // divide step counter
    logic [WIDTH-1:0] qn_q, qn_d;          // numerator dividend/quotient shift register
    logic [WIDTH-1:0] rn_q, rn_d;          // numerator partial remainder
    logic [WIDTH-1:0] qd_q, qd_d;
    logic [WIDTH-1:0] rd_q, rd_d;
    logic [WIDTH-1:0] onum_q, onum_d;
    logic [WIDTH-1:0] oden_q, oden_d;
    logic             odz_q, odz_d;

    logic             acc_sign;
    logic [WIDTH-1:0] acc_mag;
    logic [WIDTH-1:0] acc_den;
    logic [2*WIDTH-1:0] num_step;
    logic [2*WIDTH-1:0] den_step;

    // One restoring-division step: shift the next dividend bit into the remainder,
    // subtract the divisor when it fits. The difference is taken modulo 2^WIDTH,
    // which is exact because a fitting remainder is always below the divisor.
    function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] r,
                                                    input logic [WIDTH-1:0] q,
                                                    input logic [WIDTH-1:0] d);
        logic [WIDTH:0]   sh;
        logic [WIDTH-1:0] diff;
        sh   = {r, q[WIDTH-1]};
        diff = sh[WIDTH-1:0] - d;
        if (sh >= {1'b0, d}) begin
            return {diff, q[WIDTH-2:0], 1'b1};
        end
        return {sh[WIDTH-1:0], q[WIDTH-2:0], 1'b0};
    endfunction

    assign num_step = div_step(rn_q, qn_q, g_q);
    assign den_step = div_step(rd_q, qd_q, g_q);

    assign in_ready     = (state_q == IDLE);
    assign out_valid    = (state_q == DONE);
    assign out_num      = onum_q;
    assign out_den      = oden_q;
    assign out_div_zero = odz_q;

    // Split the incoming fraction into sign and unsigned magnitudes.
    always_comb begin
        acc_sign = in_num[WIDTH-1];
        acc_mag  = acc_sign ? (~in_num + ONE) : in_num;
        acc_den  = in_den;
`ifdef RAT_REDUCE_SIGN_NORM_EN
        if (in_den[WIDTH-1]) begin
            acc_sign = ~acc_sign;
            acc_den  = ~in_den + ONE;
        end
`endif
    end

    // Next-state logic: accept, Stein GCD step, divide step, and result hold.
    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        zero_d  = zero_q;
        dz_d    = dz_q;
        mag_d   = mag_q;
        den_d   = den_q;
        ga_d    = ga_q;
        gb_d    = gb_q;
        g_d     = g_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        qn_d    = qn_q;
        rn_d    = rn_q;
        qd_d    = qd_q;
        rd_d    = rd_q;
        onum_d  = onum_q;
        oden_d  = oden_q;
        odz_d   = odz_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d  = acc_sign;
                    mag_d   = acc_mag;
                    den_d   = acc_den;
                    ga_d    = acc_mag;
                    gb_d    = acc_den;
                    k_d     = '0;
                    zero_d  = (in_num == '0);
                    dz_d    = (in_den == '0);
                    state_d = GCD;
                end
            end
            GCD: begin
                if (dz_q) begin
                    onum_d  = sign_q ? (~mag_q + ONE) : mag_q;
                    oden_d  = '0;
                    odz_d   = 1'b1;
                    state_d = DONE;
                end else if (zero_q) begin
                    onum_d  = '0;
                    oden_d  = ONE;
                    odz_d   = 1'b0;
                    state_d = DONE;
                end else if (ga_q == '0 || gb_q == '0) begin
                    g_d     = (ga_q | gb_q) << k_q;
                    cnt_d   = '0;
                    qn_d    = mag_q;
                    rn_d    = '0;
                    qd_d    = den_q;
                    rd_d    = '0;
                    state_d = DIV;
                end else if (!ga_q[0] && !gb_q[0]) begin
                    ga_d = ga_q >> 1;
                    gb_d = gb_q >> 1;
                    k_d  = k_q + CW'(1);
                end else if (!ga_q[0]) begin
                    ga_d = ga_q >> 1;
                end else if (!gb_q[0]) begin
                    gb_d = gb_q >> 1;
                end else if (ga_q >= gb_q) begin
                    // difference of two odd values is even: fold in one halving
                    ga_d = (ga_q - gb_q) >> 1;
                end else begin
                    gb_d = (gb_q - ga_q) >> 1;
                end
            end
            DIV: begin
                rn_d  = num_step[2*WIDTH-1:WIDTH];
                qn_d  = num_step[WIDTH-1:0];
                rd_d  = den_step[2*WIDTH-1:WIDTH];
                qd_d  = den_step[WIDTH-1:0];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    onum_d  = sign_q ? (~qn_d + ONE) : qn_d;
                    oden_d  = qd_d;
                    odz_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset drops any in-flight work.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            zero_q  <= 1'b0;
            dz_q    <= 1'b0;
            mag_q   <= '0;
            den_q   <= '0;
            ga_q    <= '0;
            gb_q    <= '0;
            g_q     <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
            qn_q    <= '0;
            rn_q    <= '0;
            qd_q    <= '0;
            rd_q    <= '0;
            onum_q  <= '0;
            oden_q  <= '0;
            odz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            zero_q  <= zero_d;
            dz_q    <= dz_d;
            mag_q   <= mag_d;
            den_q   <= den_d;
            ga_q    <= ga_d;
            gb_q    <= gb_d;
            g_q     <= g_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            qn_q    <= qn_d;
            rn_q    <= rn_d;
            qd_q    <= qd_d;
            rd_q    <= rd_d;
            onum_q  <= onum_d;
            oden_q  <= oden_d;
            odz_q   <= odz_d;
        end
    end

endmodule

// File: tb/tb_rat_reduce.sv
// Directed bench for rat_reduce at WIDTH=8 with hand-computed reduced fractions.
// Latency: checks the 2-cycle short-cuts and the 4*WIDTH+4 bound.
// Backpressure: holds out_ready low in DONE and checks outputs stay put.
module tb_rat_reduce;

    localparam int W = 8;
    localparam int MAX_LAT = 4 * W + 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_num;
    logic [W-1:0] in_den;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_num;
    logic [W-1:0] out_den;
    logic         out_div_zero;

    int checks = 0;
    int errors = 0;

    rat_reduce #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_num       (in_num),
        .in_den       (in_den),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_num      (out_num),
        .out_den      (out_den),
        .out_div_zero (out_div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one fraction, then count cycles after the accept edge until out_valid.
    task automatic send(input string tag, input logic [W-1:0] n, input logic [W-1:0] d,
                        output int lat);
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_num   = n;
        in_den   = d;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
        check({tag, " out_valid"}, 32'(out_valid), 32'd1);
    endtask

    task automatic expect_res(input string tag, input logic [W-1:0] n, input logic [W-1:0] d,
                              input logic dz);
        check({tag, " out_num"}, 32'(out_num), 32'(n));
        check({tag, " out_den"}, 32'(out_den), 32'(d));
        check({tag, " out_div_zero"}, 32'(out_div_zero), 32'(dz));
    endtask

    task automatic release_res(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " released out_valid"}, 32'(out_valid), 32'd0);
        check({tag, " released in_ready"}, 32'(in_ready), 32'd1);
    endtask

    task automatic run(input string tag, input logic [W-1:0] n, input logic [W-1:0] d,
                       input logic [W-1:0] en, input logic [W-1:0] ed);
        int lat;
        send(tag, n, d, lat);
        check({tag, " latency bound"}, 32'(lat <= MAX_LAT), 32'd1);
        expect_res(tag, en, ed, 1'b0);
        release_res(tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_num    = '0;
        in_den    = '0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);
        expect_res("reset", 8'd0, 8'd0, 1'b0);

        // Basic reductions, including the most negative numerator.
        run("6/8", 8'd6, 8'd8, 8'd3, 8'd4);
        run("-10/4", 8'hF6, 8'd4, 8'hFB, 8'd2);
        run("-128/64", 8'h80, 8'd64, 8'hFE, 8'd1);
        run("3/4 reduced", 8'd3, 8'd4, 8'd3, 8'd4);
        run("255/17", 8'hFF, 8'd17, 8'hFF, 8'd17);
        run("-120/90", 8'h88, 8'd90, 8'hFC, 8'd3);

        // Short-cut paths: exactly 2 cycles after accept.
        send("0/7", 8'd0, 8'd7, lat);
        check("0/7 latency", 32'(lat), 32'd2);
        expect_res("0/7", 8'd0, 8'd1, 1'b0);
        release_res("0/7");

        send("5/0", 8'd5, 8'd0, lat);
        check("5/0 latency", 32'(lat), 32'd2);
        expect_res("5/0", 8'd5, 8'd0, 1'b1);
        release_res("5/0");

        send("-3/0", 8'hFD, 8'd0, lat);
        check("-3/0 latency", 32'(lat), 32'd2);
        expect_res("-3/0", 8'hFD, 8'd0, 1'b1);
        release_res("-3/0");

        // Hold the result with out_ready low for 10 cycles.
        send("9/12 hold", 8'd9, 8'd12, lat);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold out_valid", 32'(out_valid), 32'd1);
            check("hold in_ready", 32'(in_ready), 32'd0);
            expect_res("hold", 8'd3, 8'd4, 1'b0);
        end
        release_res("hold");

        // Reset in the middle of a GCD; outputs were nonzero beforehand.
        run("96/36 pre", 8'd96, 8'd36, 8'd8, 8'd3);
        in_valid = 1'b1;
        in_num   = 8'd96;
        in_den   = 8'd36;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst out_valid", 32'(out_valid), 32'd0);
        check("midrst in_ready", 32'(in_ready), 32'd1);
        expect_res("midrst", 8'd0, 8'd0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            tick();
            check("midrst no output", 32'(out_valid), 32'd0);
        end
        run("96/36 post", 8'd96, 8'd36, 8'd8, 8'd3);

`ifdef RAT_REDUCE_SIGN_NORM_EN
        run("3/-6 norm", 8'd3, 8'hFA, 8'hFF, 8'd2);
        run("-4/-6 norm", 8'hFC, 8'hFA, 8'd2, 8'd3);
`else
        run("3/250", 8'd3, 8'd250, 8'd3, 8'd250);
        run("4/250", 8'd4, 8'd250, 8'd2, 8'd125);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
